resp_sig_monitor: RTL and testbench

RESP_SIG_MONITOR -- requirements
Module: resp_sig_monitor

---
 rtl/resp_sig_monitor.sv | 141 ++++++++++++++
 tb/tb_resp_sig_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/resp_sig_monitor.sv
// Response signature monitor: compacts a qualified response stream into a
// MISR signature during a start/stop bounded run and compares the result
// against an expected signature when the run ends.
module resp_sig_monitor #(
  parameter int unsigned         DATA_W = 32,
  parameter int unsigned         SIG_W  = 32,
  parameter logic [SIG_W-1:0]    POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]    SEED   = {SIG_W{1'b1}},
  parameter int unsigned         SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic [SIG_W-1:0]  signature,
  output logic [31:0]       sample_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        o_state_dbg
);

  // Control protocol: start and stop are single-cycle pulses sampled on the
  // rising edge. start is honoured only in IDLE/DONE and wins over a
  // coincident stop there; stop is honoured only in SETTLE/CAPTURE. in_valid
  // qualifies in_data on every cycle with no backpressure: a word presented
  // with in_valid=1 during CAPTURE is always folded on that edge, including
  // the cycle that carries stop.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int unsigned NCH = (DATA_W + SIG_W - 1) / SIG_W;
  localparam logic [31:0] L_SETTLE_LOAD = (SETTLE > 0) ? 32'(SETTLE - 1) : 32'd0;

  state_t                 r_state;
  logic [SIG_W-1:0]       r_sig;
  logic [31:0]            r_cnt;
  logic [31:0]            r_settle_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;

  logic [NCH*SIG_W-1:0]   w_pad;
  logic [SIG_W-1:0]       w_fold;
  logic [SIG_W-1:0]       w_sig_shift;
  logic [SIG_W-1:0]       w_sig_cap;
  logic [31:0]            w_cnt_cap;

  // Zero-pad the response word to whole chunks and XOR the chunks together.
  always_comb begin
    w_pad = '0;
    w_pad[DATA_W-1:0] = in_data;
    w_fold = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_fold = w_fold ^ w_pad[i*SIG_W +: SIG_W];
    end
  end

  // MISR step and saturating count for the current CAPTURE cycle.
  always_comb begin
    w_sig_shift = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0);
    w_sig_cap   = r_sig;
    w_cnt_cap   = r_cnt;
    if (in_valid) begin
      w_sig_cap = w_sig_shift ^ w_fold;
      w_cnt_cap = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    end
  end

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sig        <= SEED;
      r_cnt        <= 32'd0;
      r_settle_cnt <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sig        <= SEED;
            r_cnt        <= 32'd0;
            r_pass       <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_settle_cnt <= L_SETTLE_LOAD;
            r_state      <= (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (stop) begin
            // Nothing was captured, so the compare is against the seed.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_sig == exp_sig);
          end else if (r_settle_cnt == 32'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 32'd1;
          end
        end
        S_CAPTURE: begin
          r_sig <= w_sig_cap;
          r_cnt <= w_cnt_cap;
          if (stop) begin
            // Compare includes any word folded on this same cycle.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_sig_cap == exp_sig);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign signature    = r_sig;
  assign sample_count = r_cnt;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_resp_sig_monitor.sv
// Directed bench for resp_sig_monitor. Three instances share the control
// inputs: A (8-bit data, seed 00, settle 2), B (seed 80, settle 0) and
// C (16-bit data, seed 00, settle 2).
module tb_resp_sig_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [15:0] in_data16;
  logic [7:0]  exp_sig;

  logic [7:0]  a_sig, b_sig, c_sig;
  logic [31:0] a_cnt, b_cnt, c_cnt;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic        a_pass, b_pass, c_pass;
  logic [1:0]  a_st, b_st, c_st;

  int checks;
  int failures;

  resp_sig_monitor #(.DATA_W(8), .SIG_W(8), .POLY(8'h07), .SEED(8'h00), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .exp_sig(exp_sig), .signature(a_sig), .sample_count(a_cnt),
    .busy(a_busy), .done(a_done), .pass(a_pass), .o_state_dbg(a_st)
  );

  resp_sig_monitor #(.DATA_W(8), .SIG_W(8), .POLY(8'h07), .SEED(8'h80), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .exp_sig(exp_sig), .signature(b_sig), .sample_count(b_cnt),
    .busy(b_busy), .done(b_done), .pass(b_pass), .o_state_dbg(b_st)
  );

  resp_sig_monitor #(.DATA_W(16), .SIG_W(8), .POLY(8'h07), .SEED(8'h00), .SETTLE(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data16), .exp_sig(exp_sig), .signature(c_sig), .sample_count(c_cnt),
    .busy(c_busy), .done(c_done), .pass(c_pass), .o_state_dbg(c_st)
  );

  // Clock and initial input values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one input word for one cycle.
  task automatic drive(input logic v, input logic [7:0] d, input logic stp, input logic sta);
    in_valid = v;
    in_data  = d;
    stop     = stp;
    start    = sta;
    cycle();
    in_valid = 1'b0;
    stop     = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    checks++; if (a_sig !== 8'h00) begin failures++; $display("FAIL rst_sig_a got=%h exp=%h", a_sig, 8'h00); end
    checks++; if (b_sig !== 8'h80) begin failures++; $display("FAIL rst_sig_b got=%h exp=%h", b_sig, 8'h80); end
    checks++; if (a_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    checks++; if ({a_busy, a_done, a_pass} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {a_busy, a_done, a_pass}); end
    rst_n = 1'b1;
    cycle();
    // stop while idle has no effect
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if ({a_done, a_busy, a_st} !== 4'b0000) begin failures++; $display("FAIL idle_stop got=%b exp=0000", {a_done, a_busy, a_st}); end
  endtask

  task automatic test_basic();
    exp_sig = 8'h03;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if ({a_busy, a_st} !== 3'b101) begin failures++; $display("FAIL basic_settle got=%b exp=101", {a_busy, a_st}); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    checks++; if ({a_sig, a_cnt} !== {8'h01, 32'd1}) begin failures++; $display("FAIL basic_first got=%h/%0d exp=01/1", a_sig, a_cnt); end
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (a_sig !== 8'h03) begin failures++; $display("FAIL basic_sig got=%h exp=03", a_sig); end
    checks++; if (a_cnt !== 32'd3) begin failures++; $display("FAIL basic_cnt got=%0d exp=3", a_cnt); end
    checks++; if ({a_done, a_busy, a_pass} !== 3'b101) begin failures++; $display("FAIL basic_pass got=%b exp=101", {a_done, a_busy, a_pass}); end
    // DONE holds while inputs toggle
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++; if ({a_sig, a_cnt, a_done, a_pass} !== {8'h03, 32'd3, 2'b11}) begin failures++; $display("FAIL basic_hold got=%h/%0d/%b%b exp=03/3/11", a_sig, a_cnt, a_done, a_pass); end
    // second run, mismatching expectation, start ignored mid-run
    exp_sig = 8'h04;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if ({a_sig, a_cnt} !== {8'h03, 32'd3}) begin failures++; $display("FAIL busy_start got=%h/%0d exp=03/3", a_sig, a_cnt); end
    checks++; if ({a_done, a_pass} !== 2'b10) begin failures++; $display("FAIL basic_nopass got=%b exp=10", {a_done, a_pass}); end
  endtask

  task automatic test_feedback();
    exp_sig = 8'h07;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if ({b_busy, b_st, b_sig, b_cnt} !== {1'b1, 2'd2, 8'h80, 32'd0}) begin failures++; $display("FAIL fb_start got=%b/%h/%h/%0d exp=1/2/80/0", b_busy, b_st, b_sig, b_cnt); end
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (b_sig !== 8'h07) begin failures++; $display("FAIL fb_sig got=%h exp=07", b_sig); end
    checks++; if ({b_cnt, b_done, b_pass} !== {32'd1, 2'b11}) begin failures++; $display("FAIL fb_done got=%0d/%b%b exp=1/11", b_cnt, b_done, b_pass); end
    // A saw stop while still settling
    checks++; if ({a_sig, a_cnt, a_done, a_busy, a_pass} !== {8'h00, 32'd0, 3'b100}) begin failures++; $display("FAIL settle_stop got=%h/%0d/%b exp=00/0/100", a_sig, a_cnt, {a_done, a_busy, a_pass}); end
  endtask

  task automatic test_settle_ignore();
    exp_sig = 8'h00;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++; if ({a_st, a_sig, a_cnt} !== {2'd2, 8'h00, 32'd0}) begin failures++; $display("FAIL settle_ign got=%0d/%h/%0d exp=2/00/0", a_st, a_sig, a_cnt); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if ({a_done, a_pass, a_cnt} !== {2'b11, 32'd0}) begin failures++; $display("FAIL settle_end got=%b%b/%0d exp=11/0", a_done, a_pass, a_cnt); end
  endtask

  task automatic test_stop_with_word();
    exp_sig = 8'h07;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    checks++; if ({a_sig, a_cnt} !== {8'h07, 32'd2}) begin failures++; $display("FAIL stop_word got=%h/%0d exp=07/2", a_sig, a_cnt); end
    checks++; if ({a_done, a_pass} !== 2'b11) begin failures++; $display("FAIL stop_word_pass got=%b exp=11", {a_done, a_pass}); end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if ({a_busy, a_done, a_st, a_sig, a_cnt} !== {2'b10, 2'd1, 8'h00, 32'd0}) begin failures++; $display("FAIL start_prio got=%b/%0d/%h/%0d exp=10/1/00/0", {a_busy, a_done}, a_st, a_sig, a_cnt); end
    checks++; if ({b_busy, b_st} !== 3'b110) begin failures++; $display("FAIL start_prio_b got=%b exp=110", {b_busy, b_st}); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h02;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_sig, a_cnt, a_busy, a_done, a_pass} !== {8'h00, 32'd0, 3'b000}) begin failures++; $display("FAIL async_rst_a got=%h/%0d/%b exp=00/0/000", a_sig, a_cnt, {a_busy, a_done, a_pass}); end
    checks++; if ({b_sig, b_cnt, b_busy} !== {8'h80, 32'd0, 1'b0}) begin failures++; $display("FAIL async_rst_b got=%h/%0d/%b exp=80/0/0", b_sig, b_cnt, b_busy); end
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    checks++; if ({a_st, a_busy, a_cnt} !== {3'b000, 32'd0}) begin failures++; $display("FAIL rst_release got=%0d/%b/%0d exp=0/0/0", a_st, a_busy, a_cnt); end
  endtask

  task automatic test_wide();
    exp_sig   = 8'hFF;
    in_data16 = 16'h0000;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    in_data16 = 16'hA55A;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    in_data16 = 16'h0000;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if ({c_sig, c_cnt} !== {8'hFF, 32'd1}) begin failures++; $display("FAIL wide_sig got=%h/%0d exp=ff/1", c_sig, c_cnt); end
    checks++; if ({c_done, c_pass} !== 2'b11) begin failures++; $display("FAIL wide_pass got=%b exp=11", {c_done, c_pass}); end
  endtask

  // Test sequence and final report.
  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_data16 = 16'h0000;
    exp_sig   = 8'h00;
    test_reset();
    test_basic();
    test_feedback();
    test_settle_ignore();
    test_stop_with_word();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
